// File: rtl/router_pkt_rx.sv
// Router output-port packet receiver: drains one FIFO, checks parity, streams payload.
// Optional header address check is enabled with ROUTER_PKT_RX_ADDR_CHECK_EN.
module router_pkt_rx #(
  parameter logic [1:0] PORT_ADDR = 2'd0
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  output logic       read_enb,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic [5:0] pkt_len,
  output logic [1:0] pkt_addr,
  output logic       pkt_done,
  output logic       pkt_err
`ifdef ROUTER_PKT_RX_ADDR_CHECK_EN
  ,
  output logic       addr_err
`endif
);

  // state  | meaning
  // IDLE   | no packet in progress, next read is a header
  // ACTIVE | header issued, reading payload and parity
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e     state_q;
  logic [6:0] iss_q;
  logic [6:0] cap_q;
  logic       rd_q;
  logic [7:0] acc_q;
  logic [5:0] len_q;
  logic [1:0] addr_q;
  logic       byte_valid_q;
  logic [7:0] byte_data_q;
  logic       pkt_done_q;
  logic       pkt_err_q;
  logic       addr_err_q;

  logic [6:0] last_idx;
  logic       more;

  // Until the header lands only header + one more byte are safe to request:
  // every packet is at least two bytes long.
  assign last_idx = {1'b0, len_q} + 7'd1;
  assign more     = (cap_q == 7'd0) ? (iss_q < 7'd2) : (iss_q < (last_idx + 7'd1));
  assign read_enb = resetn & vld_out & more;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      iss_q        <= '0;
      cap_q        <= '0;
      rd_q         <= 1'b0;
      acc_q        <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      pkt_done_q   <= 1'b0;
      pkt_err_q    <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      pkt_done_q   <= 1'b0;
      pkt_err_q    <= 1'b0;
      addr_err_q   <= 1'b0;
      rd_q         <= read_enb;
      if (read_enb) begin
        iss_q <= iss_q + 7'd1;
      end
      case (state_q)
        IDLE: begin
          if (read_enb) begin
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (rd_q) begin
            if (cap_q == 7'd0) begin
              len_q  <= data_out[7:2];
              addr_q <= data_out[1:0];
              acc_q  <= data_out;
              cap_q  <= 7'd1;
            end else if (cap_q == last_idx) begin
              pkt_done_q <= 1'b1;
              pkt_err_q  <= (acc_q != data_out);
              addr_err_q <= (addr_q != PORT_ADDR);
              state_q    <= IDLE;
              iss_q      <= '0;
              cap_q      <= '0;
              acc_q      <= '0;
            end else begin
              byte_data_q  <= data_out;
              byte_valid_q <= 1'b1;
              acc_q        <= acc_q ^ data_out;
              cap_q        <= cap_q + 7'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign pkt_len    = len_q;
  assign pkt_addr   = addr_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_err    = pkt_err_q;

`ifdef ROUTER_PKT_RX_ADDR_CHECK_EN
  assign addr_err = addr_err_q;
`else
  logic unused_addr_err;
  assign unused_addr_err = addr_err_q;
`endif

endmodule

// File: tb/tb_router_pkt_rx.sv
// Scoreboard bench for router_pkt_rx: FIFO model feeds packets, monitor checks outputs.
module tb_router_pkt_rx;

`ifdef ROUTER_PKT_RX_ADDR_CHECK_EN
  localparam logic [1:0] PA = 2'd2;
`else
  localparam logic [1:0] PA = 2'd0;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       vld_out = 1'b0;
  logic [7:0] data_out = 8'h00;
  logic       read_enb;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic [5:0] pkt_len;
  logic [1:0] pkt_addr;
  logic       pkt_done;
  logic       pkt_err;
`ifdef ROUTER_PKT_RX_ADDR_CHECK_EN
  logic       addr_err;
`endif

  router_pkt_rx #(.PORT_ADDR(PA)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .vld_out   (vld_out),
    .data_out  (data_out),
    .read_enb  (read_enb),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .pkt_len   (pkt_len),
    .pkt_addr  (pkt_addr),
    .pkt_done  (pkt_done),
    .pkt_err   (pkt_err)
`ifdef ROUTER_PKT_RX_ADDR_CHECK_EN
    ,
    .addr_err  (addr_err)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         is_done;
    logic [7:0] data;
    bit         err;
    logic [5:0] len;
    logic [1:0] addr;
    bit         aerr;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fifo_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         reads_total = 0;
  int         bytes_seen = 0;
  int         dones_seen = 0;
  bit         stall_rand = 0;
  bit         hold = 0;
  int         stall_at = -1;
  int         stall_left = 0;
  bit         drv_re;
  logic [7:0] drv_nb;
  ev_t        mon_ev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a packet is header, len random bytes, XOR parity (optionally inverted).
  task automatic send_pkt(input logic [7:0] hdr, input bit corrupt);
    logic [7:0] par;
    logic [7:0] b;
    ev_t        e;
    int         len;
    len = int'(hdr[7:2]);
    par = hdr;
    fifo_q.push_back(hdr);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      par = par ^ b;
      fifo_q.push_back(b);
      e.is_done = 0; e.data = b; e.err = 0;
      e.len = hdr[7:2]; e.addr = hdr[1:0]; e.aerr = 0;
      exp_q.push_back(e);
    end
    fifo_q.push_back(corrupt ? ~par : par);
    e.is_done = 1; e.data = 8'h00; e.err = corrupt;
    e.len = hdr[7:2]; e.addr = hdr[1:0]; e.aerr = (hdr[1:0] != PA);
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (fifo_q.size() == 0 && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("drain_in_budget", 32'(ok), 32'd1);
    repeat (3) @(negedge clock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read_enb"}, 32'(read_enb), 32'd0);
    chk({tag, "_pulses"}, {29'd0, byte_valid, pkt_done, pkt_err}, 32'd0);
    chk({tag, "_byte_data"}, 32'(byte_data), 32'd0);
    chk({tag, "_len_addr"}, {24'd0, pkt_len, pkt_addr}, 32'd0);
`ifdef ROUTER_PKT_RX_ADDR_CHECK_EN
    chk({tag, "_addr_err"}, 32'(addr_err), 32'd0);
`endif
  endtask

  // FIFO model: read on a rising edge with read_enb=1, data valid after that edge.
  initial begin
    forever begin
      @(negedge clock);
      if (!resetn || hold || fifo_q.size() == 0) vld_out = 1'b0;
      else if (stall_left > 0 && reads_total >= stall_at) begin
        vld_out = 1'b0;
        stall_left--;
      end else if (stall_rand && $urandom_range(3) == 0) vld_out = 1'b0;
      else vld_out = 1'b1;
      #1;
      drv_re = read_enb;
      drv_nb = 8'h00;
      if (drv_re) begin
        chk("read_enb_needs_vld", 32'(vld_out), 32'd1);
        reads_total++;
        if (fifo_q.size() > 0) drv_nb = fifo_q.pop_front();
      end
      @(posedge clock);
      #1;
      if (drv_re) data_out = drv_nb;
    end
  end

  always @(negedge clock) begin
    if (resetn && (byte_valid || pkt_done)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {30'd0, byte_valid, pkt_done}, 32'd0);
      end else begin
        mon_ev = exp_q.pop_front();
        chk("event_kind", {30'd0, byte_valid, pkt_done}, mon_ev.is_done ? 32'd1 : 32'd2);
        chk("pkt_len", 32'(pkt_len), 32'(mon_ev.len));
        chk("pkt_addr", 32'(pkt_addr), 32'(mon_ev.addr));
        if (mon_ev.is_done) begin
          dones_seen++;
          chk("pkt_err", 32'(pkt_err), 32'(mon_ev.err));
`ifdef ROUTER_PKT_RX_ADDR_CHECK_EN
          chk("addr_err", 32'(addr_err), 32'(mon_ev.aerr));
`endif
        end else begin
          bytes_seen++;
          chk("byte_data", 32'(byte_data), 32'(mon_ev.data));
        end
      end
    end
  end

  int r0, b0, d0, nbytes;
  logic [7:0] hdr;

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // len 14, good parity, no stalls
    r0 = reads_total; b0 = bytes_seen; d0 = dones_seen;
    send_pkt(8'h38, 0);
    wait_idle(200);
    chk("p38_reads", 32'(reads_total - r0), 32'd16);
    chk("p38_bytes", 32'(bytes_seen - b0), 32'd14);
    chk("p38_dones", 32'(dones_seen - d0), 32'd1);
    chk("p38_len_hold", 32'(pkt_len), 32'd14);

    // len 16, bad parity
    r0 = reads_total;
    send_pkt(8'h41, 1);
    wait_idle(200);
    chk("p41_reads", 32'(reads_total - r0), 32'd18);
    chk("p41_len_addr", {24'd0, pkt_len, pkt_addr}, {24'd0, 6'd16, 2'd1});

    // len 0: header then parity
    r0 = reads_total; b0 = bytes_seen; d0 = dones_seen;
    send_pkt(8'h01, 0);
    wait_idle(100);
    chk("p01_reads", 32'(reads_total - r0), 32'd2);
    chk("p01_bytes", 32'(bytes_seen - b0), 32'd0);
    chk("p01_dones", 32'(dones_seen - d0), 32'd1);

    // len 5 with a 3-cycle vld_out gap after payload byte 2
    r0 = reads_total; b0 = bytes_seen;
    stall_at = reads_total + 3;
    stall_left = 3;
    send_pkt(8'h14, 0);
    wait_idle(200);
    chk("stall_reads", 32'(reads_total - r0), 32'd7);
    chk("stall_bytes", 32'(bytes_seen - b0), 32'd5);
    stall_left = 0;

    // two len-2 packets back to back
    r0 = reads_total; d0 = dones_seen;
    send_pkt(8'h08, 0);
    send_pkt(8'h09, 0);
    wait_idle(200);
    chk("b2b_reads", 32'(reads_total - r0), 32'd8);
    chk("b2b_dones", 32'(dones_seen - d0), 32'd2);

    // reset after payload byte 3 of a len-10 packet
    b0 = bytes_seen; d0 = dones_seen;
    send_pkt(8'h28, 0);
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      #1;
      if (bytes_seen >= b0 + 3) break;
    end
    chk("reach_byte3", 32'(bytes_seen - b0), 32'd3);
    #1;
    resetn = 1'b0;
    #1;
    chk_all_zero("midrst");
    fifo_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clock);
    chk("midrst_no_done", 32'(dones_seen - d0), 32'd0);
    resetn = 1'b1;
    r0 = reads_total; b0 = bytes_seen; d0 = dones_seen;
    send_pkt(8'h0C, 0);
    wait_idle(100);
    chk("postrst_reads", 32'(reads_total - r0), 32'd5);
    chk("postrst_bytes", 32'(bytes_seen - b0), 32'd3);
    chk("postrst_dones", 32'(dones_seen - d0), 32'd1);

    // address field vs PORT_ADDR
    send_pkt(8'h16, 0);
    send_pkt(8'h15, 0);
    wait_idle(200);
    chk("addr_last", 32'(pkt_addr), 32'd1);

    // randomized packets with random stalls
    stall_rand = 1;
    for (int g = 0; g < 12; g++) begin
      r0 = reads_total;
      nbytes = 0;
      for (int k = 0; k < int'($urandom_range(3, 1)); k++) begin
        hdr = {6'($urandom_range(24)), 2'($urandom_range(3))};
        nbytes += int'(hdr[7:2]) + 2;
        send_pkt(hdr, $urandom_range(3) == 0);
      end
      wait_idle(800);
      chk("rand_reads", 32'(reads_total - r0), 32'(nbytes));
    end
    stall_rand = 0;

    repeat (5) @(negedge clock);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
